// File: rtl/inmp441_mic_i2s_transmitter.sv
// inmp441_mic_i2s_transmitter
//   I2S slave transmitter that stands in for an INMP441 MEMS microphone. An
//   external master owns SCK/WS; this block shifts signed samples out on SD,
//   MSB first, one SCK after the WS edge that opens its channel's slot. Samples
//   come from a small FIFO on a valid/ready interface.
//
// Ports
//   clk, rst_n    system clock (>= 8x SCK), async active-low reset
//   lr            channel select: 0 = transmit while WS=0, 1 = while WS=1
//   sck, ws       I2S bit clock / word select from master (async to clk)
//   sd, sd_oe     serial data and its output enable (tristate at top level)
//   sample_data   two's complement sample, w_sample bits
//   sample_valid  sample_data valid
//   sample_ready  FIFO not full (registered)
//   underrun      1-clk pulse: own slot started with the FIFO empty
module inmp441_mic_i2s_transmitter #(
  parameter int w_sample   = 24,
  parameter int slot_bits  = 32,
  parameter int fifo_depth = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lr,
  input  logic                sck,
  input  logic                ws,
  output logic                sd,
  output logic                sd_oe,
  input  logic [w_sample-1:0] sample_data,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                underrun
);

  localparam int PW = $clog2(fifo_depth);
  localparam int CW = $clog2(slot_bits);
  localparam logic [PW:0]   FULL    = (PW+1)'(fifo_depth);
  localparam logic [CW-1:0] BIT_MAX = CW'(slot_bits - 1);
  localparam logic [CW-1:0] W_LIM   = CW'(w_sample);

  // ---------------------------------------------------------------------------
  // SCK / WS synchronizers and falling-edge detect
  // ---------------------------------------------------------------------------
  logic sck_meta, sck_s, sck_d;
  logic ws_meta, ws_s;
  logic fe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta <= 1'b0;
      sck_s    <= 1'b0;
      sck_d    <= 1'b0;
      ws_meta  <= 1'b0;
      ws_s     <= 1'b0;
    end else begin
      sck_meta <= sck;
      sck_s    <= sck_meta;
      sck_d    <= sck_s;
      ws_meta  <= ws;
      ws_s     <= ws_meta;
    end
  end

  assign fe = sck_d & ~sck_s;

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [w_sample-1:0] mem [fifo_depth];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW:0]         count, count_nxt;
  logic                push, pop, fifo_empty;

  assign push       = sample_valid & sample_ready;
  assign fifo_empty = (count == '0);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sample_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count        <= count_nxt;
      sample_ready <= (count_nxt != FULL);
    end
  end

  // ---------------------------------------------------------------------------
  // Slot FSM: UNPRIMED until the first SCK fall, then IDLE / OWN by WS edges
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {ST_UNPRIMED, ST_IDLE, ST_OWN} state_t;
  state_t state, state_nxt;

  logic ws_last;
  logic ws_edge;
  logic slot_start, slot_end, shift_en;

  assign ws_edge = (ws_s != ws_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_UNPRIMED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (fe) begin
      case (state)
        ST_UNPRIMED: state_nxt = ST_IDLE;
        ST_IDLE:     if (ws_edge && ws_s == lr) state_nxt = ST_OWN;
        ST_OWN:      if (ws_edge && ws_s != lr) state_nxt = ST_IDLE;
        default:     state_nxt = ST_UNPRIMED;
      endcase
    end
  end

  // A WS edge in either direction is acted on from any primed state, so a
  // slot toggle that lands while already idle still forces sd_oe low.
  always_comb begin
    slot_start = 1'b0;
    slot_end   = 1'b0;
    shift_en   = 1'b0;
    if (fe && state != ST_UNPRIMED) begin
      if (ws_edge) begin
        slot_start = (ws_s == lr);
        slot_end   = (ws_s != lr);
      end else begin
        shift_en   = (state == ST_OWN);
      end
    end
  end

  // Pop sees the pre-push count, so a same-clk push into an empty FIFO is
  // kept for the following slot.
  assign pop = slot_start & ~fifo_empty;

  // ---------------------------------------------------------------------------
  // Shift datapath
  // ---------------------------------------------------------------------------
  logic [w_sample-1:0] shreg;
  logic [CW-1:0]       bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_last  <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      sd       <= 1'b0;
      sd_oe    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (fe) ws_last <= ws_s;
      if (slot_start) begin
        // sd is left alone here: this SCK period is the I2S one-bit delay.
        shreg    <= fifo_empty ? '0 : mem[rd_ptr];
        underrun <= fifo_empty;
        bit_cnt  <= '0;
        sd_oe    <= 1'b1;
      end else if (slot_end) begin
        sd_oe <= 1'b0;
        sd    <= 1'b0;
      end else if (shift_en) begin
        sd    <= (bit_cnt < W_LIM) ? shreg[w_sample-1] : 1'b0;
        shreg <= shreg << 1;
        if (bit_cnt != BIT_MAX) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inmp441_mic_i2s_transmitter.sv
// Directed bench: the bench acts as I2S master (SCK = clk/16) and reads SD just
// before each SCK rise, then compares received words against pushed samples.
module tb_inmp441_mic_i2s_transmitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lr = 1'b0;
  logic        sck = 1'b1;
  logic        ws = 1'b1;
  logic        sd, sd_oe;
  logic [23:0] sample_data = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, underrun;

  inmp441_mic_i2s_transmitter dut (
    .clk(clk), .rst_n(rst_n), .lr(lr), .sck(sck), .ws(ws),
    .sd(sd), .sd_oe(sd_oe),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // monitor: underrun pulses and rise times of sd_oe / sample_ready
  int cyc = 0, urun_cnt = 0, run = 0, max_run = 0;
  int oe_rise = 0, rdy_rise = 0;
  logic p_oe = 1'b0, p_rdy = 1'b0;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (underrun === 1'b1) begin
      urun_cnt++;
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (sd_oe && !p_oe) oe_rise = cyc;
    if (sample_ready && !p_rdy) rdy_rise = cyc;
    p_oe  = sd_oe;
    p_rdy = sample_ready;
  end

  logic cap_sd [0:63];
  logic cap_oe [0:63];

  // one WS half of n SCK periods; WS changes with the first SCK fall
  task automatic half(input logic wv, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sck = 1'b0;
      if (k == 0) ws = wv;
      repeat (8) @(negedge clk);
      cap_sd[k] = sd;
      cap_oe[k] = sd_oe;
      sck = 1'b1;
      repeat (7) @(negedge clk);
    end
  endtask

  function automatic logic [23:0] word_of();
    logic [23:0] w = '0;
    for (int k = 1; k <= 24; k++) w = {w[22:0], cap_sd[k]};
    return w;
  endfunction

  function automatic int oe_sum(input int n);
    int s = 0;
    for (int k = 0; k < n; k++) s += int'(cap_oe[k]);
    return s;
  endfunction

  function automatic logic tail_or();
    logic t = 1'b0;
    for (int k = 25; k < 32; k++) t = t | cap_sd[k];
    return t;
  endfunction

  function automatic logic sd_or(input int n);
    logic t = 1'b0;
    for (int k = 0; k < n; k++) t = t | cap_sd[k];
    return t;
  endfunction

  task automatic push(input logic [23:0] d);
    @(negedge clk);
    sample_data  = d;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_reset(input logic lr_v);
    @(negedge clk);
    rst_n = 1'b0;
    lr = lr_v;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  logic        acc [0:2];
  logic [23:0] v3 [0:2];
  int          base;
  logic [10:0] top11;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_sd", sd, 0);
    chk("rst_oe", sd_oe, 0);
    chk("rst_rdy", sample_ready, 1);
    chk("rst_urun", underrun, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // basic word, lr=0
    push(24'hA50F3C);
    half(1'b1, 32);                      // first fall only primes
    half(1'b0, 32);
    chk("t2_word", word_of(), 24'hA50F3C);
    chk("t2_tail", tail_or(), 0);
    chk("t2_oe_own", oe_sum(32), 32);
    half(1'b1, 32);
    chk("t2_oe_foreign", oe_sum(32), 0);
    chk("t2_sd_foreign", sd_or(32), 0);
    chk("t2_urun", urun_cnt, 0);

    // underruns with no samples
    base = urun_cnt;
    for (int f = 0; f < 3; f++) begin
      half(1'b0, 32);
      chk("t3_zero", sd_or(32), 0);
      half(1'b1, 32);
    end
    chk("t3_urun_cnt", urun_cnt - base, 3);
    chk("t3_urun_width", max_run, 1);
    chk("t3_rdy", sample_ready, 1);

    // FIFO full, ordering
    base = urun_cnt;
    v3[0] = 24'h123456; v3[1] = 24'h654321; v3[2] = 24'hDEAD01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample_data  = v3[i];
      sample_valid = 1'b1;
      acc[i] = sample_ready;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    chk("t4_acc0", acc[0], 1);
    chk("t4_acc1", acc[1], 1);
    chk("t4_acc2", acc[2], 0);
    chk("t4_full", sample_ready, 0);
    rdy_rise = -1000;
    half(1'b0, 32);
    chk("t4_rdy_lat", ((rdy_rise - oe_rise) >= 0) && ((rdy_rise - oe_rise) <= 2), 1);
    chk("t4_word0", word_of(), 24'h123456);
    half(1'b1, 32);
    half(1'b0, 32);
    chk("t4_word1", word_of(), 24'h654321);
    half(1'b1, 32);
    chk("t4_urun", urun_cnt - base, 0);

    // lr=1
    do_reset(1'b1);
    base = urun_cnt;
    push(24'h7FFFFF);
    push(24'h800000);
    half(1'b0, 32);                      // primes
    chk("t5_oe_prime", oe_sum(32), 0);
    half(1'b1, 32);
    chk("t5_word0", word_of(), 24'h7FFFFF);
    chk("t5_oe_own", oe_sum(32), 32);
    half(1'b0, 32);
    chk("t5_oe_foreign", oe_sum(32), 0);
    half(1'b1, 32);
    chk("t5_word1", word_of(), 24'h800000);
    chk("t5_urun", urun_cnt - base, 0);

    // reset mid-word
    do_reset(1'b0);
    base = urun_cnt;
    push(24'hFFF000);
    push(24'h111111);
    half(1'b1, 32);
    half(1'b0, 11);                      // stop after bit 10
    push(24'h222222);
    chk("t6_full", sample_ready, 0);
    chk("t6_sd_pre", sd, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_sd", sd, 0);
    chk("t6_oe", sd_oe, 0);
    chk("t6_rdy", sample_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push(24'h0ABCDE);
    half(1'b1, 32);                      // primes
    half(1'b0, 32);
    chk("t6_word", word_of(), 24'h0ABCDE);
    chk("t6_urun", urun_cnt - base, 0);

    // truncated word
    do_reset(1'b0);
    base = urun_cnt;
    push(24'hF0F0F0);
    push(24'h0F1E2D);
    half(1'b1, 32);
    half(1'b0, 12);
    top11 = '0;
    for (int k = 1; k <= 11; k++) top11 = {top11[9:0], cap_sd[k]};
    chk("t7_trunc", top11, 11'b11110000111);
    half(1'b1, 32);
    chk("t7_oe_foreign", oe_sum(32), 0);
    half(1'b0, 32);
    chk("t7_word", word_of(), 24'h0F1E2D);
    chk("t7_urun", urun_cnt - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
